rmap_bus_arbiter: RTL and testbench
===================================

# rmap_bus_arbiter

- **Purpose:** two-master arbiter that shares the single internal memory/register bus between the RMAP target's bus master (master 0) and the local host bus master (master 1).
- **Arbitration:** round-robin with bus-cycle locking.
- **Timeout:** it owns the bus watchdog and generates the timeout error returned to the granted master.
- **Placement:** sits between the RMAP target top-level and the register/memory slave.

## Interface
Parameters:
- BUS_WIDTH, 32, data width; must be a multiple of 8
- TIMEOUT_CYCLES, 255, strobe-without-acknowledge cycles before timeout; at least 1

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- m0Cycle, m1Cycle  in  1  bus request/lock per master
- m0Strobe, m1Strobe  in  1  transfer strobe
- m0Address, m1Address  in  32  byte address
- m0ByteEnable, m1ByteEnable  in  BUS_WIDTH/8  byte lanes
- m0DataOut, m1DataOut  in  BUS_WIDTH  write data from master
- m0WriteEnable, m1WriteEnable  in  1  write qualifier
- m0ReadEnable, m1ReadEnable  in  1  read qualifier
- m0DataIn, m1DataIn  out  BUS_WIDTH  read data to master
- m0Acknowledge, m1Acknowledge  out  1  transfer done
- m0TimeOutError, m1TimeOutError  out  1  one-cycle timeout pulse
- sCycle, sStrobe, sWriteEnable, sReadEnable  out  1  slave control
- sAddress  out  32  slave address
- sByteEnable  out  BUS_WIDTH/8  slave byte lanes
- sDataOut  out  BUS_WIDTH  slave write data
- sDataIn  in  BUS_WIDTH  slave read data
- sAcknowledge  in  1  slave acknowledge
- grant  out  2  one-hot current owner; 00 = idle

## Operation
**States:** IDLE, GRANT0, GRANT1. A `lastGrant` bit records the most recent owner.

**IDLE**
- Only m0Cycle high → GRANT0. Only m1Cycle high → GRANT1.
- Both high → grant the master that is not `lastGrant`.
- Neither high → stay in IDLE.

**GRANTn**
- Slave outputs are driven combinationally from master n.
- sAcknowledge is routed to mnAcknowledge; sDataIn is routed to mnDataIn.
- The non-granted master sees Acknowledge = 0, TimeOutError = 0 and DataIn = 0.
- Exit to IDLE in the cycle after mnCycle is sampled low; `lastGrant` ← n on exit.
- The grant is locked while mnCycle stays high, across any number of strobes, including after a timeout.

**IDLE outputs:** all slave outputs are 0 and grant = 00.

**Watchdog**
- The counter increments each cycle in which the granted master has Strobe = 1 and sAcknowledge = 0.
- It clears on sAcknowledge, on Strobe = 0, or on any state change.
- When the count reaches TIMEOUT_CYCLES−1 with no acknowledge in that cycle:
  - mnTimeOutError pulses for exactly one cycle (the TIMEOUT_CYCLES-th unacknowledged strobe cycle);
  - the counter clears;
  - sStrobe is forced to 0 for that cycle.
- The master must deassert Strobe or Cycle; if Strobe stays high, counting restarts.
- Counter width is clog2(TIMEOUT_CYCLES+1). It saturates, never wraps.

**Boundary rules**
- sAcknowledge and the expiry condition in the same cycle: acknowledge wins, no timeout.
- sAcknowledge while in IDLE: ignored.
- mnCycle falling in the same cycle as an acknowledge: the acknowledge is still delivered, then the state goes to IDLE.
- rst asserted mid-transfer: next edge → IDLE, counter 0, `lastGrant` = 1 (master 0 wins the first tie); the in-flight transfer is abandoned with no acknowledge and no timeout.

## Timing
- **Reset values:** every output is 0, grant = 00.
- **Grant latency:** 1 cycle. A request sampled in IDLE at edge k gives grant and slave outputs valid after edge k.
- **Acknowledge/data path:** combinational (zero-cycle) from slave to granted master.
- **Release:** 1 dead IDLE cycle between tenures. Back-to-back alternating ownership costs 1 cycle.
- **Timeout latency:** error asserted in the TIMEOUT_CYCLES-th consecutive unacknowledged strobe cycle.

## Structure
- Package `rmap_bus_pkg` holds:
  - the state enum (IDLE, GRANT0, GRANT1);
  - the 2-bit one-hot grant constants GRANT_NONE, GRANT_M0, GRANT_M1.
- Sub-module `rmap_bus_watchdog`:
  - parameter TIMEOUT_CYCLES;
  - inputs clk, rst, clear, strobe, ack;
  - output expire.
- The state register, `lastGrant` and the output muxing stay in the top module.

## Test plan
- **Reset:** hold rst 3 cycles with both Cycles high → all outputs 0 and grant = 00. Release → grant = 01 one cycle later.
- **Single master:** m1 writes 0xDEADBEEF to 0x40 with BE = 1111, slave acks after 2 cycles → sAddress = 0x40, m1Acknowledge one cycle, m0 untouched.
- **Contention round-robin:** both Cycles held with one-strobe tenures → grant sequence 01, 00, 10, 00, 01; master 1 requesting during m0's tenure waits until m0Cycle drops.
- **Lock:** m0 issues 4 strobes under one Cycle while m1 requests → grant stays 01 for all 4 acknowledges.
- **Timeout:** TIMEOUT_CYCLES = 8, no acknowledge → m0TimeOutError high in strobe cycle 8 only, sStrobe low that cycle. With acknowledge in cycle 8 → acknowledge and no timeout.
- **Reset mid-tenure:** rst during GRANT1 strobe → IDLE next cycle, counter cleared, no acknowledge/error; a subsequent tie grants m0.

Source files
------------

// File: rtl/rmap_bus_pkg.sv
// Shared types and constants for the RMAP two-master bus arbiter.
// Holds the arbiter state encoding and the one-hot grant codes.
package rmap_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } bus_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/rmap_bus_watchdog.sv
// Bus watchdog: counts consecutive unacknowledged strobe cycles and flags
// expiry on the TIMEOUT_CYCLES-th one, then restarts from zero.
module rmap_bus_watchdog
  import rmap_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic strobe,
  input  logic ack,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT   = {CW{1'b1}};

  logic [CW-1:0] count;

  // Expiry is suppressed by an acknowledge in the same cycle and by reset.
  always_comb begin
    expire = 1'b0;
    if (!rst && strobe && !ack && (count == LIMIT)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

  // Saturating counter of unacknowledged strobe cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear || ack || !strobe || expire) begin
      count <= '0;
    end else if (count != SAT) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/rmap_bus_arbiter.sv
// Round-robin arbiter sharing the register/memory bus between the RMAP
// target master (m0) and the local host master (m1), with cycle locking.
module rmap_bus_arbiter
  import rmap_bus_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0Cycle,
  input  logic                   m0Strobe,
  input  logic [31:0]            m0Address,
  input  logic [BUS_WIDTH/8-1:0] m0ByteEnable,
  input  logic [BUS_WIDTH-1:0]   m0DataOut,
  input  logic                   m0WriteEnable,
  input  logic                   m0ReadEnable,
  output logic [BUS_WIDTH-1:0]   m0DataIn,
  output logic                   m0Acknowledge,
  output logic                   m0TimeOutError,
  input  logic                   m1Cycle,
  input  logic                   m1Strobe,
  input  logic [31:0]            m1Address,
  input  logic [BUS_WIDTH/8-1:0] m1ByteEnable,
  input  logic [BUS_WIDTH-1:0]   m1DataOut,
  input  logic                   m1WriteEnable,
  input  logic                   m1ReadEnable,
  output logic [BUS_WIDTH-1:0]   m1DataIn,
  output logic                   m1Acknowledge,
  output logic                   m1TimeOutError,
  output logic                   sCycle,
  output logic                   sStrobe,
  output logic                   sWriteEnable,
  output logic                   sReadEnable,
  output logic [31:0]            sAddress,
  output logic [BUS_WIDTH/8-1:0] sByteEnable,
  output logic [BUS_WIDTH-1:0]   sDataOut,
  input  logic [BUS_WIDTH-1:0]   sDataIn,
  input  logic                   sAcknowledge,
  output logic [1:0]             grant
);

  bus_state_t state;
  bus_state_t next_state;
  logic       last_grant;
  logic       wd_clear;
  logic       wd_strobe;
  logic       expire;

  // Next-state: ties go to the master that did not own the bus last.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m0Cycle && m1Cycle) begin
          next_state = last_grant ? GRANT0 : GRANT1;
        end else if (m0Cycle) begin
          next_state = GRANT0;
        end else if (m1Cycle) begin
          next_state = GRANT1;
        end else begin
          next_state = IDLE;
        end
      end
      GRANT0: begin
        if (!m0Cycle) begin
          next_state = IDLE;
        end else begin
          next_state = GRANT0;
        end
      end
      GRANT1: begin
        if (!m1Cycle) begin
          next_state = IDLE;
        end else begin
          next_state = GRANT1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and round-robin history; reset favours master 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= next_state;
      if (state == GRANT0 && next_state == IDLE) begin
        last_grant <= 1'b0;
      end else if (state == GRANT1 && next_state == IDLE) begin
        last_grant <= 1'b1;
      end else begin
        last_grant <= last_grant;
      end
    end
  end

  assign wd_clear = (state != next_state);

  rmap_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wd_clear),
    .strobe(wd_strobe),
    .ack   (sAcknowledge),
    .expire(expire)
  );

  // Output steering: the owner sees the slave directly, the other sees zeros.
  always_comb begin
    sCycle         = 1'b0;
    sStrobe        = 1'b0;
    sWriteEnable   = 1'b0;
    sReadEnable    = 1'b0;
    sAddress       = '0;
    sByteEnable    = '0;
    sDataOut       = '0;
    m0DataIn       = '0;
    m0Acknowledge  = 1'b0;
    m0TimeOutError = 1'b0;
    m1DataIn       = '0;
    m1Acknowledge  = 1'b0;
    m1TimeOutError = 1'b0;
    wd_strobe      = 1'b0;
    grant          = GRANT_NONE;
    case (state)
      GRANT0: begin
        sCycle         = m0Cycle;
        sStrobe        = m0Strobe & ~expire;
        sWriteEnable   = m0WriteEnable;
        sReadEnable    = m0ReadEnable;
        sAddress       = m0Address;
        sByteEnable    = m0ByteEnable;
        sDataOut       = m0DataOut;
        m0DataIn       = sDataIn;
        m0Acknowledge  = sAcknowledge;
        m0TimeOutError = expire;
        wd_strobe      = m0Strobe;
        grant          = GRANT_M0;
      end
      GRANT1: begin
        sCycle         = m1Cycle;
        sStrobe        = m1Strobe & ~expire;
        sWriteEnable   = m1WriteEnable;
        sReadEnable    = m1ReadEnable;
        sAddress       = m1Address;
        sByteEnable    = m1ByteEnable;
        sDataOut       = m1DataOut;
        m1DataIn       = sDataIn;
        m1Acknowledge  = sAcknowledge;
        m1TimeOutError = expire;
        wd_strobe      = m1Strobe;
        grant          = GRANT_M1;
      end
      default: begin
        grant = GRANT_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_rmap_bus_arbiter.sv
// Self-checking bench for rmap_bus_arbiter: a per-cycle vector table fed
// through a scoreboard queue, then a bounded timeout-latency sequence.
module tb_rmap_bus_arbiter;

  localparam int BW = 32;
  localparam int TO = 8;

  localparam logic [31:0] M0_ADDR = 32'h0000_0100;
  localparam logic [3:0]  M0_BE   = 4'b0101;
  localparam logic [31:0] M0_DATA = 32'h1234_5678;
  localparam logic [31:0] M1_ADDR = 32'h0000_0040;
  localparam logic [3:0]  M1_BE   = 4'b1111;
  localparam logic [31:0] M1_DATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          m0Cycle = 1'b0, m0Strobe = 1'b0, m1Cycle = 1'b0, m1Strobe = 1'b0;
  logic [31:0]   m0Address = M0_ADDR, m1Address = M1_ADDR;
  logic [3:0]    m0ByteEnable = M0_BE, m1ByteEnable = M1_BE;
  logic [BW-1:0] m0DataOut = M0_DATA, m1DataOut = M1_DATA;
  logic          m0WriteEnable = 1'b0, m0ReadEnable = 1'b1;
  logic          m1WriteEnable = 1'b1, m1ReadEnable = 1'b0;
  logic [BW-1:0] m0DataIn, m1DataIn;
  logic          m0Acknowledge, m1Acknowledge, m0TimeOutError, m1TimeOutError;
  logic          sCycle, sStrobe, sWriteEnable, sReadEnable;
  logic [31:0]   sAddress;
  logic [3:0]    sByteEnable;
  logic [BW-1:0] sDataOut;
  logic [BW-1:0] sDataIn = '0;
  logic          sAcknowledge = 1'b0;
  logic [1:0]    grant;

  rmap_bus_arbiter #(.BUS_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0Cycle(m0Cycle), .m0Strobe(m0Strobe), .m0Address(m0Address),
    .m0ByteEnable(m0ByteEnable), .m0DataOut(m0DataOut),
    .m0WriteEnable(m0WriteEnable), .m0ReadEnable(m0ReadEnable),
    .m0DataIn(m0DataIn), .m0Acknowledge(m0Acknowledge), .m0TimeOutError(m0TimeOutError),
    .m1Cycle(m1Cycle), .m1Strobe(m1Strobe), .m1Address(m1Address),
    .m1ByteEnable(m1ByteEnable), .m1DataOut(m1DataOut),
    .m1WriteEnable(m1WriteEnable), .m1ReadEnable(m1ReadEnable),
    .m1DataIn(m1DataIn), .m1Acknowledge(m1Acknowledge), .m1TimeOutError(m1TimeOutError),
    .sCycle(sCycle), .sStrobe(sStrobe), .sWriteEnable(sWriteEnable), .sReadEnable(sReadEnable),
    .sAddress(sAddress), .sByteEnable(sByteEnable), .sDataOut(sDataOut),
    .sDataIn(sDataIn), .sAcknowledge(sAcknowledge), .grant(grant)
  );

  typedef struct {
    logic       rst, c0, s0, c1, s1, ack;
    logic [1:0] grant;
    logic       sstb, a0, a1, t0, t1;
  } vec_t;

  typedef struct {
    logic [1:0]  grant;
    logic        scyc, sstb, we, re, a0, a1, t0, t1;
    logic [31:0] addr, dout, d0, d1;
    logic [3:0]  be;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input logic r, c0, s0, c1, s1, ack, input logic [1:0] g,
                             input logic sstb, a0, a1, t0, t1);
    vec_t x;
    x.rst = r; x.c0 = c0; x.s0 = s0; x.c1 = c1; x.s1 = s1; x.ack = ack;
    x.grant = g; x.sstb = sstb; x.a0 = a0; x.a1 = a1; x.t0 = t0; x.t1 = t1;
    return x;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    exp_t e, got;
    logic sel0, sel1;
    logic [31:0] sdata;
    int hit;

    // Reset held with both masters requesting, then release.
    for (int i = 0; i < 3; i++) vecs.push_back(v(1,1,0,1,0,0, 2'b00, 0,0,0,0,0));
    vecs.push_back(v(0,1,0,1,0,0, 2'b00, 0,0,0,0,0));
    vecs.push_back(v(0,1,1,1,0,0, 2'b01, 1,0,0,0,0));
    vecs.push_back(v(0,1,1,1,0,1, 2'b01, 1,1,0,0,0));
    vecs.push_back(v(0,0,0,1,0,0, 2'b01, 0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,0,0, 2'b00, 0,0,0,0,0));
    // m1 write to 0x40, acked in its third strobe cycle, m0 waiting.
    vecs.push_back(v(0,1,0,1,1,0, 2'b10, 1,0,0,0,0));
    vecs.push_back(v(0,1,0,1,1,0, 2'b10, 1,0,0,0,0));
    vecs.push_back(v(0,1,0,1,1,1, 2'b10, 1,0,1,0,0));
    vecs.push_back(v(0,1,0,0,0,0, 2'b10, 0,0,0,0,0));
    // Round-robin under contention; row 14 drops Cycle together with an ack.
    vecs.push_back(v(0,1,0,1,0,0, 2'b00, 0,0,0,0,0));
    vecs.push_back(v(0,1,1,1,0,1, 2'b01, 1,1,0,0,0));
    vecs.push_back(v(0,0,1,1,0,1, 2'b01, 1,1,0,0,0));
    vecs.push_back(v(0,1,0,1,0,0, 2'b00, 0,0,0,0,0));
    vecs.push_back(v(0,1,0,1,1,1, 2'b10, 1,0,1,0,0));
    vecs.push_back(v(0,1,0,0,0,0, 2'b10, 0,0,0,0,0));
    vecs.push_back(v(0,1,0,1,0,0, 2'b00, 0,0,0,0,0));
    // Lock: four acknowledged strobes for m0 while m1 requests.
    vecs.push_back(v(0,1,1,1,0,1, 2'b01, 1,1,0,0,0));
    vecs.push_back(v(0,1,0,1,0,0, 2'b01, 0,0,0,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(0,1,1,1,0,1, 2'b01, 1,1,0,0,0));
    vecs.push_back(v(0,0,0,1,0,0, 2'b01, 0,0,0,0,0));
    // Acknowledge in IDLE is ignored.
    vecs.push_back(v(0,0,0,0,0,1, 2'b00, 0,0,0,0,0));
    // Timeout on strobe cycle 8, restart, then ack in cycle 8 beats expiry.
    vecs.push_back(v(0,1,0,0,0,0, 2'b00, 0,0,0,0,0));
    for (int i = 0; i < 7; i++) vecs.push_back(v(0,1,1,0,0,0, 2'b01, 1,0,0,0,0));
    vecs.push_back(v(0,1,1,0,0,0, 2'b01, 0,0,0,1,0));
    vecs.push_back(v(0,1,1,0,0,0, 2'b01, 1,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,0, 2'b01, 0,0,0,0,0));
    for (int i = 0; i < 7; i++) vecs.push_back(v(0,1,1,0,0,0, 2'b01, 1,0,0,0,0));
    vecs.push_back(v(0,1,1,0,0,1, 2'b01, 1,1,0,0,0));
    vecs.push_back(v(0,1,1,0,0,0, 2'b01, 1,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 2'b01, 0,0,0,0,0));
    // Reset in the middle of an m1 tenure; the following tie goes to m0.
    vecs.push_back(v(0,0,0,1,0,0, 2'b00, 0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,1,0, 2'b10, 1,0,0,0,0));
    vecs.push_back(v(1,0,0,1,1,0, 2'b10, 1,0,0,0,0));
    vecs.push_back(v(0,1,0,1,1,1, 2'b00, 0,0,0,0,0));
    vecs.push_back(v(0,1,0,1,0,0, 2'b01, 0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,0,0, 2'b01, 0,0,0,0,0));

    for (int r = 0; r < vecs.size(); r++) begin
      @(posedge clk);
      #1;
      sdata = 32'hA5A5_0000 | r;
      rst = vecs[r].rst;
      m0Cycle = vecs[r].c0; m0Strobe = vecs[r].s0;
      m1Cycle = vecs[r].c1; m1Strobe = vecs[r].s1;
      sAcknowledge = vecs[r].ack;
      sDataIn = sdata;
      sel0 = (vecs[r].grant == 2'b01);
      sel1 = (vecs[r].grant == 2'b10);
      e.grant = vecs[r].grant;
      e.sstb  = vecs[r].sstb;
      e.a0 = vecs[r].a0; e.a1 = vecs[r].a1; e.t0 = vecs[r].t0; e.t1 = vecs[r].t1;
      e.scyc = sel0 ? vecs[r].c0 : (sel1 ? vecs[r].c1 : 1'b0);
      e.addr = sel0 ? M0_ADDR : (sel1 ? M1_ADDR : 32'h0);
      e.be   = sel0 ? M0_BE   : (sel1 ? M1_BE   : 4'h0);
      e.dout = sel0 ? M0_DATA : (sel1 ? M1_DATA : 32'h0);
      e.we   = sel1;
      e.re   = sel0;
      e.d0   = sel0 ? sdata : 32'h0;
      e.d1   = sel1 ? sdata : 32'h0;
      sb.push_back(e);

      @(negedge clk);
      if (sb.size() == 0) begin
        chk("scoreboard_empty", r, 32'd0, 32'd1);
      end else begin
        got = sb.pop_front();
        chk("grant",   r, {30'd0, grant},          {30'd0, got.grant});
        chk("sCycle",  r, {31'd0, sCycle},         {31'd0, got.scyc});
        chk("sStrobe", r, {31'd0, sStrobe},        {31'd0, got.sstb});
        chk("sWE",     r, {31'd0, sWriteEnable},   {31'd0, got.we});
        chk("sRE",     r, {31'd0, sReadEnable},    {31'd0, got.re});
        chk("sAddr",   r, sAddress,                got.addr);
        chk("sBE",     r, {28'd0, sByteEnable},    {28'd0, got.be});
        chk("sDout",   r, sDataOut,                got.dout);
        chk("m0Ack",   r, {31'd0, m0Acknowledge},  {31'd0, got.a0});
        chk("m1Ack",   r, {31'd0, m1Acknowledge},  {31'd0, got.a1});
        chk("m0TO",    r, {31'd0, m0TimeOutError}, {31'd0, got.t0});
        chk("m1TO",    r, {31'd0, m1TimeOutError}, {31'd0, got.t1});
        chk("m0DataIn", r, m0DataIn,               got.d0);
        chk("m1DataIn", r, m1DataIn,               got.d1);
      end
    end

    // Timeout latency for m1: bounded wait for the error pulse.
    @(posedge clk); #1;
    rst = 1'b0; m0Cycle = 1'b0; m0Strobe = 1'b0; sAcknowledge = 1'b0;
    m1Cycle = 1'b1; m1Strobe = 1'b0;
    @(posedge clk); #1;
    m1Strobe = 1'b1;
    hit = 0;
    for (int n = 1; n <= 20 && hit == 0; n++) begin
      @(negedge clk);
      chk("to_grant", 1000 + n, {30'd0, grant}, 32'd2);
      chk("to_m0err", 1000 + n, {31'd0, m0TimeOutError}, 32'd0);
      if (m1TimeOutError) begin
        hit = n;
        chk("to_sstrobe", 1000 + n, {31'd0, sStrobe}, 32'd0);
      end else begin
        chk("to_sstrobe", 1000 + n, {31'd0, sStrobe}, 32'd1);
      end
      @(posedge clk); #1;
    end
    chk("to_latency", 2000, hit, TO);
    @(negedge clk);
    chk("to_pulse_once", 2001, {31'd0, m1TimeOutError}, 32'd0);
    m1Cycle = 1'b0; m1Strobe = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_release", 2002, {30'd0, grant}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
